// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back stage: entry layout, load size
// encoding and load-data extension.
package wb_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;
  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned NUM_REGS     = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]   rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_entry_t;

  // Sign- or zero-extend an LSB-aligned load value to the full word.
  function automatic logic [XLEN_DEFAULT-1:0] load_extend(
    input logic [XLEN_DEFAULT-1:0] data,
    input mem_size_e               size,
    input logic                    is_unsigned
  );
    logic [XLEN_DEFAULT-1:0] r;
    case (size)
      SZ_B:    r = {{(XLEN_DEFAULT-8){data[7] & ~is_unsigned}},   data[7:0]};
      SZ_H:    r = {{(XLEN_DEFAULT-16){data[15] & ~is_unsigned}}, data[15:0]};
      SZ_W:    r = {{(XLEN_DEFAULT-32){data[31] & ~is_unsigned}}, data[31:0]};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries; exposes per-slot rd and valid bits
// so the parent can track which registers have loads in flight.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  wb_entry_t                        push_entry,
  input  logic                             pop,
  output wb_entry_t                        head,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(DEPTH):0]           count,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd,
  output logic [DEPTH-1:0]                 entry_valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t              r_mem [DEPTH];
  logic [DEPTH-1:0]       r_valid;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   w_do_push;
  logic                   w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Payload storage needs no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_rd
    assign entry_rd[i] = r_mem[i].rd;
  end
  assign entry_valid = r_valid;

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: arbitrates ALU results over buffered load results and drives
// the register bank write port. Define WB_STATS_EN to add the stall_cycles counter.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  output logic                  wb_regwrite,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]       wb_data,
  output logic [NUM_REGS-1:0]   pending_mask
`ifdef WB_STATS_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                                  w_alu_win;
  logic                                  w_push;
  logic                                  w_pop;
  logic                                  w_full;
  logic                                  w_empty;
  logic [CNT_W-1:0]                      w_count;
  wb_entry_t                             w_push_entry;
  wb_entry_t                             w_head;
  logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] w_entry_rd;
  logic [FIFO_DEPTH-1:0]                 w_entry_valid;
  logic [NUM_REGS-1:0]                   w_pending;
  logic                                  r_regwrite;
  logic [REG_ADDR_W-1:0]                 r_rd;
  logic [XLEN-1:0]                       r_data;

  assign w_alu_win = alu_valid && (alu_rd != '0);
  assign w_pop     = !w_alu_win && !w_empty;
  assign mem_ready = !rst && (w_count < CNT_W'(FIFO_DEPTH));
  // Loads to x0 complete the handshake but never occupy a slot.
  assign w_push    = mem_valid && !rst && !w_full && (mem_rd != '0);

  assign w_push_entry.rd   = mem_rd;
  assign w_push_entry.data = load_extend(XLEN_DEFAULT'(mem_data), mem_size_e'(mem_size),
                                         mem_unsigned);

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .head       (w_head),
    .full       (w_full),
    .empty      (w_empty),
    .count      (w_count),
    .entry_rd   (w_entry_rd),
    .entry_valid(w_entry_valid)
  );

  // Output register: ALU has priority, else FIFO head, else hold rd/data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_data     <= '0;
    end else if (w_alu_win) begin
      r_regwrite <= 1'b1;
      r_rd       <= alu_rd;
      r_data     <= alu_data;
    end else if (w_pop) begin
      r_regwrite <= 1'b1;
      r_rd       <= w_head.rd;
      r_data     <= XLEN'(w_head.data);
    end else begin
      r_regwrite <= 1'b0;
    end
  end

  assign wb_regwrite = r_regwrite;
  assign wb_rd       = r_rd;
  assign wb_data     = r_data;

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (w_entry_valid[i]) begin
        w_pending[w_entry_rd[i]] = 1'b1;
      end
    end
  end
  assign pending_mask = w_pending;

`ifdef WB_STATS_EN
  logic [31:0] r_stall_cycles;

  // Counts cycles where a buffered load is held off by an ALU write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (w_alu_win && !w_empty && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end
  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
Write-back stage directly upstream of the 64-bit register bank. Merges single-cycle ALU results with long-latency load results arriving over a valid/ready handshake. Sign- or zero-extends load data and buffers loads in a small FIFO. Drives the bank's write port (regwrite, register3, datain) from a registered output.

Parameters:
XLEN, 64, data width; matches register bank word.
FIFO_DEPTH, 4, load-result FIFO entries; power of two, >=2.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
alu_valid  in  1  ALU result present this cycle; no backpressure.
alu_rd  in  5  ALU destination register.
alu_data  in  XLEN  ALU result.
mem_valid  in  1  load result offered.
mem_ready  out  1  unit accepts a load this cycle.
mem_rd  in  5  load destination register.
mem_data  in  XLEN  raw load data, LSB-aligned.
mem_size  in  2  0=byte, 1=half, 2=word, 3=double.
mem_unsigned  in  1  1=zero-extend, 0=sign-extend.
wb_regwrite  out  1  to bank regwrite.
wb_rd  out  5  to bank register3.
wb_data  out  XLEN  to bank datain.
pending_mask  out  32  bit i set iff a FIFO entry targets register i.

Behaviour:
- Reset: FIFO emptied; wb_regwrite=0, wb_rd=0, wb_data=0, pending_mask=0; mem_ready=0 while rst=1. Reset mid-operation discards all buffered loads without writing them.
- Load handshake: transfer when mem_valid && mem_ready at a posedge. mem_ready = !rst && (count < FIFO_DEPTH). mem_ready is low when full even if a pop occurs in the same cycle.
- Extension applied at enqueue:
  - byte: bits [7:0] extended from bit 7.
  - half: bits [15:0] extended from bit 15.
  - word: bits [31:0] extended from bit 31.
  - double: passed unchanged.
  - mem_unsigned=1 fills upper bits with 0.
- Loads with mem_rd=0 are accepted (handshake completes) but not enqueued.
- ALU results with alu_rd=0 are ignored and do not consume the write slot.
- Arbitration each cycle, ALU first:
  - If alu_valid && alu_rd!=0, the ALU owns the slot and the FIFO head waits.
  - Else, if the FIFO is non-empty, the head is popped.
  - Else, no write.
- Output register loaded at posedge from the winner. wb_regwrite=1 for exactly one cycle per write. With no winner, wb_regwrite=0 and wb_rd/wb_data hold their previous values.
- Latency:
  - ALU: wb_* valid in the cycle after alu_valid (1 cycle).
  - Load into empty FIFO with no ALU contention: accepted at edge N, wb_* valid after edge N+1 (2 cycles).
  - Each ALU-occupied cycle adds 1 cycle.
- Ordering: loads written in acceptance order. ALU and load writes to the same rd are not reordered relative to each other by this unit; upstream uses pending_mask to avoid issuing such ALU writes.
- Simultaneous push and pop when not full: both occur; count is unchanged.
- pending_mask is combinational from valid FIFO entries only. The entry being popped clears its bit the cycle after the pop edge. The entry being pushed sets its bit the cycle after the push edge.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.

Optional Feature:
WB_STATS_EN:
- Defined: adds output stall_cycles (32 bits). It is cleared by rst and increments (saturating at 2^32-1) on every cycle where the FIFO is non-empty and the ALU wins arbitration.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package wb_pkg:
  - XLEN_DEFAULT=64, REG_ADDR_W=5, NUM_REGS=32.
  - enum mem_size_e {SZ_B, SZ_H, SZ_W, SZ_D}.
  - struct wb_entry_t {rd[4:0], data[XLEN-1:0]}.
  - function load_extend(data, size, unsigned).
- Sub-module wb_fifo: synchronous FIFO of wb_entry_t with push/pop/full/empty/count. It exposes entry rd fields and valid bits so the parent can build pending_mask.

Test Plan:
1. Reset, then alu_valid=1, alu_rd=5, alu_data=0x1234 for one cycle -> next cycle wb_regwrite=1, wb_rd=5, wb_data=0x1234; following cycle wb_regwrite=0.
2. Load mem_rd=3, mem_data=0x80, size=byte, unsigned=0, no ALU traffic -> two cycles later wb_data=0xFFFFFFFFFFFFFF80, wb_rd=3. Same stimulus with unsigned=1 -> wb_data=0x80.
3. Accept 4 loads (rd=1..4) while ALU writes every cycle (rd=10) -> mem_ready=0 after the 4th, pending_mask=0x1E. Release ALU -> rd 1,2,3,4 written on consecutive cycles and pending_mask returns to 0.
4. Load mem_rd=0 and ALU alu_rd=0 -> handshake completes, wb_regwrite stays 0, pending_mask stays 0.
5. Fill FIFO with 3 entries, assert rst for one cycle -> wb_regwrite=0, pending_mask=0, mem_ready=0 during reset and 1 after; none of the 3 entries is ever written.
6. With WB_STATS_EN defined: 2 loads buffered plus 5 ALU cycles -> stall_cycles=5. Without it, scenarios 1-5 pass unchanged.
